// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage MIPS pipeline: decides each cycle
// whether to run, stall, wait on data memory, or redirect, and counts stalls/flushes.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       In_IDRs,
    input  logic [4:0]       In_IDRt,
    input  logic             In_IDUsesRt,
    input  logic             In_IDBranch,
    input  logic             In_PCSrc,
    input  logic             In_Jump,
    input  logic             In_EXMemRead,
    input  logic             In_EXRegWrite,
    input  logic [4:0]       In_EXWriteReg,
    input  logic             In_MEMMemRead,
    input  logic [4:0]       In_MEMWriteReg,
    input  logic             In_MemBusy,
    output logic             OutPCWrite,
    output logic             OutIFIDWrite,
    output logic             OutIFIDFlush,
    output logic             OutIDEXBubble,
    output logic             OutPipeHold,
    output logic [1:0]       OutState,
    output logic [CNT_W-1:0] OutStallCount,
    output logic [CNT_W-1:0] OutFlushCount
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        WAIT     = 2'd2,
        REDIRECT = 2'd3
    } actionE;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    actionE state;
    actionE action;
    logic   loadUse;
    logic   branchAlu;
    logic   branchMemLoad;
    logic   hazard;

    // $0 is hardwired, so a write to it can never create a dependency.
    function automatic logic regMatch(input logic [4:0] dst);
        return (dst != 5'd0) &&
               ((dst == In_IDRs) || (In_IDUsesRt && (dst == In_IDRt)));
    endfunction

    always_comb begin
        loadUse       = In_EXMemRead && regMatch(In_EXWriteReg);
        branchAlu     = In_IDBranch && In_EXRegWrite && !In_EXMemRead &&
                        regMatch(In_EXWriteReg);
        branchMemLoad = In_IDBranch && In_MEMMemRead && regMatch(In_MEMWriteReg);
        hazard        = loadUse || branchAlu || branchMemLoad;
    end

    always_comb begin
        // NOTE: every output gets a default before the priority chain, so no
        // path leaves a signal unassigned and no latch is inferred.
        action        = RUN;
        OutPCWrite    = 1'b1;
        OutIFIDWrite  = 1'b1;
        OutIFIDFlush  = 1'b0;
        OutIDEXBubble = 1'b0;
        OutPipeHold   = 1'b0;

        if (Reset) begin
            OutPCWrite    = 1'b0;
            OutIFIDWrite  = 1'b0;
            OutIFIDFlush  = 1'b1;
            OutIDEXBubble = 1'b1;
        end else if (In_MemBusy) begin
            action       = WAIT;
            OutPCWrite   = 1'b0;
            OutIFIDWrite = 1'b0;
            OutPipeHold  = 1'b1;
        end else if (hazard) begin
            // The branch compare uses stale operands here, so PCSrc/Jump are ignored.
            action        = STALL;
            OutPCWrite    = 1'b0;
            OutIFIDWrite  = 1'b0;
            OutIDEXBubble = 1'b1;
        end else if (In_PCSrc || In_Jump) begin
            action       = REDIRECT;
            OutIFIDFlush = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= RUN;
            OutStallCount <= '0;
            OutFlushCount <= '0;
        end else begin
            state <= action;
            if ((action == STALL || action == WAIT) && OutStallCount != CNT_MAX)
                OutStallCount <= OutStallCount + 1'b1;
            if (action == REDIRECT && OutFlushCount != CNT_MAX)
                OutFlushCount <= OutFlushCount + 1'b1;
        end
    end

    assign OutState = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: a driver queues hand-computed expectations,
// a negedge monitor pops and compares them against a 16-bit and a 2-bit-counter DUT.
module tb_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  In_IDRs, In_IDRt, In_EXWriteReg, In_MEMWriteReg;
    logic        In_IDUsesRt, In_IDBranch, In_PCSrc, In_Jump;
    logic        In_EXMemRead, In_EXRegWrite, In_MEMMemRead, In_MemBusy;

    logic        pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold;
    logic [1:0]  state;
    logic [15:0] stallCount, flushCount;

    logic        sPcWrite, sIfidWrite, sIfidFlush, sIdexBubble, sPipeHold;
    logic [1:0]  sState, sStallCount, sFlushCount;

    always #5 Clk = ~Clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .In_IDRs(In_IDRs), .In_IDRt(In_IDRt), .In_IDUsesRt(In_IDUsesRt),
        .In_IDBranch(In_IDBranch), .In_PCSrc(In_PCSrc), .In_Jump(In_Jump),
        .In_EXMemRead(In_EXMemRead), .In_EXRegWrite(In_EXRegWrite),
        .In_EXWriteReg(In_EXWriteReg), .In_MEMMemRead(In_MEMMemRead),
        .In_MEMWriteReg(In_MEMWriteReg), .In_MemBusy(In_MemBusy),
        .OutPCWrite(pcWrite), .OutIFIDWrite(ifidWrite), .OutIFIDFlush(ifidFlush),
        .OutIDEXBubble(idexBubble), .OutPipeHold(pipeHold), .OutState(state),
        .OutStallCount(stallCount), .OutFlushCount(flushCount)
    );

    hazard_ctrl #(.CNT_W(2)) dutSat (
        .Clk(Clk), .Reset(Reset),
        .In_IDRs(In_IDRs), .In_IDRt(In_IDRt), .In_IDUsesRt(In_IDUsesRt),
        .In_IDBranch(In_IDBranch), .In_PCSrc(In_PCSrc), .In_Jump(In_Jump),
        .In_EXMemRead(In_EXMemRead), .In_EXRegWrite(In_EXRegWrite),
        .In_EXWriteReg(In_EXWriteReg), .In_MEMMemRead(In_MEMMemRead),
        .In_MEMWriteReg(In_MEMWriteReg), .In_MemBusy(In_MemBusy),
        .OutPCWrite(sPcWrite), .OutIFIDWrite(sIfidWrite), .OutIFIDFlush(sIfidFlush),
        .OutIDEXBubble(sIdexBubble), .OutPipeHold(sPipeHold), .OutState(sState),
        .OutStallCount(sStallCount), .OutFlushCount(sFlushCount)
    );

    // Control vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold}
    localparam logic [4:0] C_RST = 5'b00110;
    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_STL = 5'b00010;
    localparam logic [4:0] C_WAI = 5'b00001;
    localparam logic [4:0] C_RDR = 5'b11100;

    typedef struct {
        string      name;
        logic [4:0] ctrl;
        logic [1:0] st;
        int         stall;
        int         flush;
    } expT;

    expT expQ[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (expQ.size() > 0) begin
            expT e;
            int  satS, satF;
            e    = expQ.pop_front();
            satS = (e.stall > 3) ? 3 : e.stall;
            satF = (e.flush > 3) ? 3 : e.flush;
            vectors++;
            check({e.name, ".ctrl"},
                  {27'd0, pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold}, {27'd0, e.ctrl});
            check({e.name, ".state"},  {30'd0, state},      {30'd0, e.st});
            check({e.name, ".stall"},  {16'd0, stallCount}, e.stall);
            check({e.name, ".flush"},  {16'd0, flushCount}, e.flush);
            check({e.name, ".sctrl"},
                  {27'd0, sPcWrite, sIfidWrite, sIfidFlush, sIdexBubble, sPipeHold}, {27'd0, e.ctrl});
            check({e.name, ".sstall"}, {30'd0, sStallCount}, satS);
            check({e.name, ".sflush"}, {30'd0, sFlushCount}, satF);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    // State and counters reflect actions taken in earlier cycles.
    task automatic vec(input string name, input logic rst,
                       input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic br, input logic pcs, input logic jmp,
                       input logic exMr, input logic exRw, input logic [4:0] exWr,
                       input logic memMr, input logic [4:0] memWr, input logic busy,
                       input logic [4:0] ctrl, input logic [1:0] st,
                       input int stall, input int flush);
        expT e;
        Reset = rst;          In_IDRs = rs;          In_IDRt = rt;
        In_IDUsesRt = ur;     In_IDBranch = br;      In_PCSrc = pcs;
        In_Jump = jmp;        In_EXMemRead = exMr;   In_EXRegWrite = exRw;
        In_EXWriteReg = exWr; In_MEMMemRead = memMr; In_MEMWriteReg = memWr;
        In_MemBusy = busy;
        e.name = name; e.ctrl = ctrl; e.st = st; e.stall = stall; e.flush = flush;
        expQ.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        In_IDRs = '0; In_IDRt = '0; In_IDUsesRt = 0; In_IDBranch = 0; In_PCSrc = 0;
        In_Jump = 0; In_EXMemRead = 0; In_EXRegWrite = 0; In_EXWriteReg = '0;
        In_MEMMemRead = 0; In_MEMWriteReg = '0; In_MemBusy = 0;
        @(posedge Clk);
        #1;
        //   name          rst rs  rt  ur br pc j  exMr exRw exWr mMr mWr busy ctrl  st  stl fl
        vec("rst0",        1, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RST, 0, 0,  0);
        vec("rst1",        1, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RST, 0, 0,  0);
        vec("run0",        0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 0, 0,  0);
        vec("loaduse",     0, 2,  0,  0, 0, 0, 0, 1,   1,   2,   0,  0,  0,   C_STL, 0, 0,  0);
        vec("afterlu",     0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 1, 1,  0);
        vec("reg0",        0, 0,  0,  0, 0, 0, 0, 1,   1,   0,   0,  0,  0,   C_RUN, 0, 1,  0);
        vec("rtunused",    0, 1,  5,  0, 0, 0, 0, 1,   1,   5,   0,  0,  0,   C_RUN, 0, 1,  0);
        vec("rtused",      0, 1,  5,  1, 0, 0, 0, 1,   1,   5,   0,  0,  0,   C_STL, 0, 1,  0);
        vec("afterrt",     0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 1, 2,  0);
        vec("brldEX",      0, 3,  0,  0, 1, 1, 0, 1,   1,   3,   0,  0,  0,   C_STL, 0, 2,  0);
        vec("brldMEM",     0, 3,  0,  0, 1, 0, 0, 0,   0,   0,   1,  3,  0,   C_STL, 1, 3,  0);
        vec("brtaken",     0, 3,  0,  0, 1, 1, 0, 0,   0,   0,   0,  0,  0,   C_RDR, 1, 4,  0);
        vec("afterbr",     0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 3, 4,  1);
        vec("bralu",       0, 1,  4,  1, 1, 0, 0, 0,   1,   4,   0,  0,  0,   C_STL, 0, 4,  1);
        vec("nonbralu",    0, 1,  4,  1, 0, 0, 0, 0,   1,   4,   0,  0,  0,   C_RUN, 1, 5,  1);
        vec("busy0",       0, 6,  0,  0, 0, 0, 0, 1,   1,   6,   0,  0,  1,   C_WAI, 0, 5,  1);
        vec("busy1",       0, 6,  0,  0, 0, 0, 0, 1,   1,   6,   0,  0,  1,   C_WAI, 2, 6,  1);
        vec("busy2",       0, 6,  0,  0, 0, 0, 0, 1,   1,   6,   0,  0,  1,   C_WAI, 2, 7,  1);
        vec("busyhaz",     0, 6,  0,  0, 0, 0, 0, 1,   1,   6,   0,  0,  0,   C_STL, 2, 8,  1);
        vec("afterbusy",   0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 1, 9,  1);
        vec("busybr",      0, 7,  0,  0, 1, 1, 0, 0,   0,   0,   0,  0,  1,   C_WAI, 0, 9,  1);
        vec("brafterbusy", 0, 7,  0,  0, 1, 1, 0, 0,   0,   0,   0,  0,  0,   C_RDR, 2, 10, 1);
        vec("jump",        0, 0,  0,  0, 0, 0, 1, 0,   0,   0,   0,  0,  0,   C_RDR, 3, 10, 2);
        vec("afterjump",   0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 3, 10, 3);
        vec("brmemreg0",   0, 0,  0,  1, 1, 0, 0, 0,   0,   0,   1,  0,  0,   C_RUN, 0, 10, 3);
        vec("rstmid0",     1, 2,  0,  0, 0, 0, 0, 1,   1,   2,   0,  0,  0,   C_RST, 0, 10, 3);
        vec("rstmid1",     1, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RST, 0, 0,  0);
        vec("postrst",     0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 0, 0,  0);
        for (int i = 0; i < 5; i++)
            vec($sformatf("sat%0d", i),
                           0, 2,  0,  0, 0, 0, 0, 1,   1,   2,   0,  0,  0,   C_STL, (i == 0) ? 0 : 1, i, 0);
        vec("aftersat",    0, 0,  0,  0, 0, 0, 0, 0,   0,   0,   0,  0,  0,   C_RUN, 1, 5,  0);

        // Bounded drain: the monitor must consume every queued expectation.
        for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge Clk);
        #1;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
